// File: rtl/game_clock_ctrl.sv
// Game clock controller for a minesweeper-style board.
// Counts elapsed play time in seconds and minutes, supports pause/resume,
// freezes the time when the game ends, saturates at MAX_MINUTES:59, and
// remembers the fastest winning time until the next hardware reset.
module game_clock_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MINUTES   = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       game_won,
    input  logic       game_lost,
    input  logic       new_game,
    output logic [5:0] seconds,
    output logic [6:0] minutes,
    output logic [1:0] state,
    output logic       sec_tick,
    output logic       saturated,
    output logic [5:0] best_seconds,
    output logic [6:0] best_minutes,
    output logic       best_valid,
    output logic       new_best
);

    // A one-cycle second (TICKS_PER_SEC == 1) still needs a one-bit counter.
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    MIN_LAST   = 7'(MAX_MINUTES);
    localparam logic [5:0]    SEC_LAST   = 6'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Registered state and outputs.
    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [5:0]      r_sec;
    logic [6:0]      r_min;
    logic            r_secTick;
    logic            r_sat;
    logic [5:0]      r_bestSec;
    logic [6:0]      r_bestMin;
    logic            r_bestValid;
    logic            r_newBest;

    // Next-state values produced by the combinational FSM.
    state_t          w_nextState;
    logic [PW-1:0]   w_nextPresc;
    logic [5:0]      w_nextSec;
    logic [6:0]      w_nextMin;
    logic            w_nextSecTick;
    logic            w_nextSat;
    logic [5:0]      w_nextBestSec;
    logic [6:0]      w_nextBestMin;
    logic            w_nextBestValid;
    logic            w_nextNewBest;

    // Helper terms shared by the FSM.
    logic            w_tick;
    logic            w_atLimit;
    logic            w_isFaster;
    logic [PW-1:0]   w_prescInc;

    // The prescaler wraps on its last count; that wrap is the second tick.
    assign w_tick     = (r_state == RUN) && (r_presc == PRESC_LAST);
    assign w_prescInc = (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);

    // Time is held once it reaches MAX_MINUTES:59.
    assign w_atLimit  = (r_min == MIN_LAST) && (r_sec == SEC_LAST);

    // A win replaces the record only when strictly faster, or when no record exists.
    assign w_isFaster = !r_bestValid || ({r_min, r_sec} < {r_bestMin, r_bestSec});

    // Next-state and next-output logic; new_game outranks every other input,
    // and an accepted end-of-game or pause event swallows a coincident tick.
    always_comb begin
        w_nextState     = r_state;
        w_nextPresc     = r_presc;
        w_nextSec       = r_sec;
        w_nextMin       = r_min;
        w_nextSecTick   = 1'b0;
        w_nextSat       = r_sat;
        w_nextBestSec   = r_bestSec;
        w_nextBestMin   = r_bestMin;
        w_nextBestValid = r_bestValid;
        w_nextNewBest   = 1'b0;

        if (new_game) begin
            w_nextState = IDLE;
            w_nextPresc = '0;
            w_nextSec   = '0;
            w_nextMin   = '0;
            w_nextSat   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_nextState = RUN;
                        w_nextPresc = '0;
                        w_nextSec   = '0;
                        w_nextMin   = '0;
                        w_nextSat   = 1'b0;
                    end
                end

                RUN: begin
                    w_nextPresc = w_prescInc;
                    if (game_won) begin
                        w_nextState = DONE;
                        if (w_isFaster) begin
                            w_nextBestSec   = r_sec;
                            w_nextBestMin   = r_min;
                            w_nextBestValid = 1'b1;
                            w_nextNewBest   = 1'b1;
                        end
                    end else if (game_lost) begin
                        w_nextState = DONE;
                    end else if (pause) begin
                        w_nextState = PAUSE;
                    end else if (w_tick) begin
                        if (w_atLimit) begin
                            w_nextSat = 1'b1;
                        end else if (r_sec == SEC_LAST) begin
                            w_nextSec     = '0;
                            w_nextMin     = r_min + 7'd1;
                            w_nextSecTick = 1'b1;
                        end else begin
                            w_nextSec     = r_sec + 6'd1;
                            w_nextSecTick = 1'b1;
                        end
                    end
                end

                PAUSE: begin
                    if (game_won) begin
                        w_nextState = DONE;
                        if (w_isFaster) begin
                            w_nextBestSec   = r_sec;
                            w_nextBestMin   = r_min;
                            w_nextBestValid = 1'b1;
                            w_nextNewBest   = 1'b1;
                        end
                    end else if (game_lost) begin
                        w_nextState = DONE;
                    end else if (pause) begin
                        w_nextState = RUN;
                    end
                end

                DONE: begin
                    w_nextState = DONE;
                end

                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_secTick   <= 1'b0;
            r_sat       <= 1'b0;
            r_bestSec   <= '0;
            r_bestMin   <= '0;
            r_bestValid <= 1'b0;
            r_newBest   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_presc     <= w_nextPresc;
            r_sec       <= w_nextSec;
            r_min       <= w_nextMin;
            r_secTick   <= w_nextSecTick;
            r_sat       <= w_nextSat;
            r_bestSec   <= w_nextBestSec;
            r_bestMin   <= w_nextBestMin;
            r_bestValid <= w_nextBestValid;
            r_newBest   <= w_nextNewBest;
        end
    end

    assign state        = r_state;
    assign seconds      = r_sec;
    assign minutes      = r_min;
    assign sec_tick     = r_secTick;
    assign saturated    = r_sat;
    assign best_seconds = r_bestSec;
    assign best_minutes = r_bestMin;
    assign best_valid   = r_bestValid;
    assign new_best     = r_newBest;

endmodule
